// File: rtl/rc4_key_search_sched.sv
// Top-level RC4 key-search scheduler: walks candidate keys through init, KSA and
// decrypt/check sub-blocks, and lends the single S-memory port to the active one.
module rc4_key_search_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int KEY_W  = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              found,
  output logic [KEY_W-1:0]  key,
  output logic              t1_start,
  output logic              t2_start,
  output logic              t3_start,
  input  logic              t1_done,
  input  logic              t2_done,
  input  logic              t3_done,
  input  logic              t3_fail,
  input  logic [ADDR_W-1:0] t1_address,
  input  logic [ADDR_W-1:0] t2_address,
  input  logic [ADDR_W-1:0] t3_address,
  input  logic [DATA_W-1:0] t1_data,
  input  logic [DATA_W-1:0] t2_data,
  input  logic [DATA_W-1:0] t3_data,
  input  logic              t1_wren,
  input  logic              t2_wren,
  input  logic              t3_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_GO,
    S_INIT_WAIT,
    S_KSA_GO,
    S_KSA_WAIT,
    S_DEC_GO,
    S_DEC_WAIT,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  localparam logic [KEY_W-1:0] KEY_LAST = '1;

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) begin
          key_d   = '0;
          state_d = S_INIT_GO;
        end
      end
      S_INIT_GO:   state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (t1_done) state_d = S_KSA_GO;
      S_KSA_GO:    state_d = S_KSA_WAIT;
      S_KSA_WAIT:  if (t2_done) state_d = S_DEC_GO;
      S_DEC_GO:    state_d = S_DEC_WAIT;
      S_DEC_WAIT: begin
        if (t3_done) begin
          if (!t3_fail) begin
            state_d = S_FOUND;
          end else if (key_q == KEY_LAST) begin
            // last key failed: hold it rather than wrapping back to 0
            state_d = S_EXHAUSTED;
          end else begin
            key_d   = key_q + KEY_W'(1);
            state_d = S_INIT_GO;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  assign t1_start = (state_q == S_INIT_GO);
  assign t2_start = (state_q == S_KSA_GO);
  assign t3_start = (state_q == S_DEC_GO);
  assign done     = (state_q == S_FOUND) || (state_q == S_EXHAUSTED);
  assign found    = (state_q == S_FOUND);
  assign key      = key_q;

  // one-hot grant; a zero grant vector leaves the memory port all-zero
  logic [2:0]        grant;
  logic [ADDR_W-1:0] sub_addr [3];
  logic [DATA_W-1:0] sub_data [3];
  logic              sub_wren [3];
  logic [ADDR_W-1:0] addr_m   [3];
  logic [DATA_W-1:0] data_m   [3];
  logic              wren_m   [3];

  assign grant[0] = (state_q == S_INIT_GO) || (state_q == S_INIT_WAIT);
  assign grant[1] = (state_q == S_KSA_GO)  || (state_q == S_KSA_WAIT);
  assign grant[2] = (state_q == S_DEC_GO)  || (state_q == S_DEC_WAIT);

  assign sub_addr[0] = t1_address;
  assign sub_addr[1] = t2_address;
  assign sub_addr[2] = t3_address;
  assign sub_data[0] = t1_data;
  assign sub_data[1] = t2_data;
  assign sub_data[2] = t3_data;
  assign sub_wren[0] = t1_wren;
  assign sub_wren[1] = t2_wren;
  assign sub_wren[2] = t3_wren;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_mask
      assign addr_m[gi] = sub_addr[gi] & {ADDR_W{grant[gi]}};
      assign data_m[gi] = sub_data[gi] & {DATA_W{grant[gi]}};
      assign wren_m[gi] = sub_wren[gi] & grant[gi];
    end
  endgenerate

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_address = mem_address | addr_m[i];
      mem_data    = mem_data | data_m[i];
      mem_wren    = mem_wren | wren_m[i];
    end
  end

endmodule

// File: tb/tb_rc4_key_search_sched.sv
// Randomised bench for rc4_key_search_sched: stub sub-blocks with random latencies,
// outcome of each search predicted from the number of failing passes.
module tb_rc4_key_search_sched;

  localparam int KW   = 3;
  localparam int KMAX = (1 << KW) - 1;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          done, found;
  logic [KW-1:0] key;
  logic          t1_start, t2_start, t3_start;
  logic          t1_done, t2_done, t3_done, t3_fail;
  logic [7:0]    t1_address, t2_address, t3_address;
  logic [7:0]    t1_data, t2_data, t3_data;
  logic          t1_wren, t2_wren, t3_wren;
  logic [7:0]    mem_address, mem_data;
  logic          mem_wren;

  int   total = 0;
  int   bad   = 0;
  int   t1_cnt = 0;
  logic iso = 1'b0;

  always #5 clk = ~clk;
  always @(negedge clk) if (t1_start) t1_cnt++;

  rc4_key_search_sched #(.ADDR_W(8), .DATA_W(8), .KEY_W(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .found(found), .key(key),
    .t1_start(t1_start), .t2_start(t2_start), .t3_start(t3_start),
    .t1_done(t1_done), .t2_done(t2_done), .t3_done(t3_done), .t3_fail(t3_fail),
    .t1_address(t1_address), .t2_address(t2_address), .t3_address(t3_address),
    .t1_data(t1_data), .t2_data(t2_data), .t3_data(t3_data),
    .t1_wren(t1_wren), .t2_wren(t2_wren), .t3_wren(t3_wren),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // gnt: 0 = nobody, 1..3 = sub-block; st = {t1,t2,t3} start pulses
  task automatic check_outputs(input string where, input int gnt, input logic [2:0] st,
                               input logic dn, input logic fd, input logic [KW-1:0] k);
    logic [16:0] em;
    case (gnt)
      1:       em = {t1_wren, t1_address, t1_data};
      2:       em = {t2_wren, t2_address, t2_data};
      3:       em = {t3_wren, t3_address, t3_data};
      default: em = '0;
    endcase
    chk({where, ".start"}, 32'({t1_start, t2_start, t3_start}), 32'(st));
    chk({where, ".mem"}, 32'({mem_wren, mem_address, mem_data}), 32'(em));
    chk({where, ".status"}, 32'({done, found, key}), 32'({dn, fd, k}));
  endtask

  task automatic noise(input logic spur);
    t1_data = 8'($urandom); t2_data = 8'($urandom); t3_data = 8'($urandom);
    t1_address = iso ? 8'h11 : 8'($urandom);
    t2_address = iso ? 8'h22 : 8'($urandom);
    t3_address = iso ? 8'h33 : 8'($urandom);
    t1_wren = iso ? 1'b1 : 1'($urandom);
    t2_wren = iso ? 1'b1 : 1'($urandom);
    t3_wren = iso ? 1'b1 : 1'($urandom);
    if (spur) begin
      start = 1'($urandom); t1_done = 1'($urandom); t2_done = 1'($urandom);
      t3_done = 1'($urandom); t3_fail = 1'($urandom);
    end else begin
      start = 1'b0; t1_done = 1'b0; t2_done = 1'b0; t3_done = 1'b0; t3_fail = 1'b0;
    end
  endtask

  // One sub-block pass: GO cycle (c=0) then dly WAIT cycles; done answered at c=dly.
  task automatic phase(input int n, input int dly, input logic fail, input logic spur,
                       input int rst_c, input logic [KW-1:0] k, output logic aborted);
    aborted = 1'b0;
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk);
      check_outputs($sformatf("p%0d.c%0d", n, c), n, (c == 0) ? (3'b100 >> (n - 1)) : 3'b000,
                    1'b0, 1'b0, k);
      noise(spur);
      if (spur && n == 1) t2_done = 1'b1;
      if (spur && n == 2) start = 1'b1;
      case (n)
        1: t1_done = (c == dly);
        2: t2_done = (c == dly);
        default: begin
          t3_done = (c == dly);
          if (c == dly) t3_fail = fail;
        end
      endcase
      if (c == rst_c) begin
        reset = 1'b1; t3_done = 1'b1; t3_fail = 1'b1;
        aborted = 1'b1;
        return;
      end
    end
  endtask

  // Candidate p fails iff p < nfail. Called right after a negedge check.
  task automatic run_search(input int nfail, input logic spur, input int rst_pass,
                            input int fixed_dly);
    int base, p, dly, rc, exp_passes;
    logic fail, ab, exp_found;
    logic [KW-1:0] exp_key;
    base = t1_cnt;
    p = 0;
    start = 1'b1;
    forever begin
      fail = (p < nfail);
      for (int n = 1; n <= 3; n++) begin
        dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 5));
        rc  = (n == 3 && p == rst_pass) ? int'($urandom_range(1, dly)) : -1;
        phase(n, dly, fail, spur, rc, KW'(p), ab);
        if (ab) return;
      end
      if (!fail || p == KMAX) break;
      p++;
    end
    exp_found  = (nfail <= KMAX);
    exp_key    = exp_found ? KW'(nfail) : KW'(KMAX);
    exp_passes = exp_found ? nfail + 1 : KMAX + 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs("end", 0, 3'b000, 1'b1, exp_found, exp_key);
      noise(spur);
      start = 1'b0;
    end
    chk("passes", 32'(t1_cnt - base), 32'(exp_passes));
    $display("search nfail=%0d spur=%0d: key=%0h found=%0b passes=%0d", nfail, spur, key,
             found, t1_cnt - base);
  endtask

  task automatic idle_cycles(input string where, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs(where, 0, 3'b000, 1'b0, 1'b0, '0);
      noise(1'b1);
      start = 1'b0;
      reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    noise(1'b0);
    repeat (2) begin
      @(negedge clk);
      check_outputs("reset", 0, 3'b000, 1'b0, 1'b0, '0);
    end
    reset = 1'b0;
    idle_cycles("idle", 3);

    run_search(0, 1'b0, -1, 4);
    run_search(3, 1'b0, -1, 0);
    run_search(100, 1'b0, -1, 0);
    iso = 1'b1;
    run_search(2, 1'b1, -1, 0);
    iso = 1'b0;

    run_search(5, 1'b0, 2, 0);
    @(negedge clk);
    check_outputs("midrst", 0, 3'b000, 1'b0, 1'b0, '0);
    reset = 1'b0;
    noise(1'b0);
    $display("reset in DEC_WAIT at key 2: key=%0h done=%0b", key, done);
    idle_cycles("postrst", 2);
    run_search(1, 1'b1, -1, 0);

    for (int i = 0; i < 4; i++)
      run_search(int'($urandom_range(0, 9)), 1'($urandom), -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc4_key_search_sched.md
Name: rc4_key_search_sched

Overview:
- Top-level scheduler for the RC4 key-search datapath.
- Sequences three sub-blocks per candidate key: S-memory init (S[i]=i), key-scheduling (KSA swap pass) and decrypt/check.
- Owns the single S-memory write/read port and muxes it to whichever sub-block currently holds the grant.
- On a failed decrypt check it advances the candidate key and restarts from init, until success or key-space exhaustion.

Parameters:
- ADDR_W, 8, S-memory address width.
- DATA_W, 8, S-memory data width.
- KEY_W, 22, candidate key counter width; key space is 0 .. 2^KEY_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a search at key 0; sampled only in IDLE, FOUND, EXHAUSTED
- done  out  1  search finished (level)
- found  out  1  valid with done: 1 = key found, 0 = key space exhausted
- key  out  KEY_W  current / final candidate key
- t1_start, t2_start, t3_start  out  1 each  one-cycle start pulses to init, KSA, decrypt
- t1_done, t2_done, t3_done  in  1 each  sub-block completion
- t3_fail  in  1  qualifies t3_done: 1 = plaintext check failed
- tN_address (N=1..3)  in  ADDR_W  sub-block memory address
- tN_data (N=1..3)  in  DATA_W  sub-block write data
- tN_wren (N=1..3)  in  1  sub-block write enable
- mem_address  out  ADDR_W  to S-memory
- mem_data  out  DATA_W  to S-memory
- mem_wren  out  1  to S-memory

Behaviour:
- States:
  - IDLE
  - INIT_GO, INIT_WAIT
  - KSA_GO, KSA_WAIT
  - DEC_GO, DEC_WAIT
  - FOUND
  - EXHAUSTED
- Reset (any state, including mid-search): next state IDLE; key=0, done=0, found=0, all tN_start=0. The memory port is forced to address=0, data=0, wren=0 from the same edge.
- IDLE: start=1 clears key to 0 and goes to INIT_GO.
- INIT_GO:
  - t1_start=1 for exactly this one cycle.
  - Next state INIT_WAIT unconditionally.
- INIT_WAIT: stay until t1_done=1, then KSA_GO.
- KSA_GO: t2_start=1 for this one cycle, then KSA_WAIT.
- KSA_WAIT: stay until t2_done=1, then DEC_GO.
- DEC_GO: t3_start=1 for this one cycle, then DEC_WAIT.
- DEC_WAIT: wait for t3_done=1, then:
  - t3_fail=0: go to FOUND.
  - t3_fail=1 and key < 2^KEY_W-1: key <= key+1, go to INIT_GO.
  - t3_fail=1 and key = 2^KEY_W-1: key holds (no wrap), go to EXHAUSTED.
- FOUND: done=1, found=1, key held. start=1 clears key to 0 and goes to INIT_GO.
- EXHAUSTED: done=1, found=0, key held. start=1 restarts as in FOUND.
- Output timing:
  - tN_start, done and found are Moore outputs decoded from the state register.
  - Latency from start sampled in IDLE to t1_start high is 1 cycle.
  - Latency from a tN_done sampled high to the next t(N+1)_start is 1 cycle.
- Grant mux (combinational from state):
  - INIT_GO/INIT_WAIT: sub-block 1 drives the memory port.
  - KSA_GO/KSA_WAIT: sub-block 2.
  - DEC_GO/DEC_WAIT: sub-block 3.
  - All other states: mem_wren=0, mem_address=0, mem_data=0.
  - A non-granted sub-block's wren never reaches memory.
- Spurious events:
  - tN_done in any state other than its own WAIT is ignored, including done held high from a previous pass.
  - t3_fail without t3_done is ignored.
  - start in GO/WAIT states is ignored.
- Simultaneous t3_done and reset: reset wins; key returns to 0.
- Key increment uses KEY_W-bit arithmetic; carry-out never occurs because of the exhaustion check.

Test Plan:
- Reset then single pass, all outputs checked:
  - Stimulus: reset 2 cycles; start pulse at cycle 5; sub-block stubs answer done 4 cycles after their start; t3_fail=0.
  - Response: t1_start at cycle 6, then t2_start and t3_start one cycle after each done; FOUND with done=1, found=1, key=0.
- Retry path:
  - Stimulus: t3_fail=1 on the first 3 decrypt passes, 0 on the 4th.
  - Response: exactly 4 t1_start pulses; key steps 0,1,2,3; finish FOUND with key=3.
- Exhaustion with KEY_W=3:
  - Stimulus: t3_fail always 1.
  - Response: 8 passes; EXHAUSTED with done=1, found=0, key=7; no wrap to 0.
- Grant isolation:
  - Stimulus: all three stubs drive wren=1 with distinct addresses 0x11, 0x22, 0x33 throughout.
  - Response: mem_address follows the granted sub-block only; mem_wren=0 in IDLE and FOUND.
- Robustness:
  - Stimulus: t2_done stuck high during INIT_WAIT; start pulsed during KSA_WAIT.
  - Response: no premature transition and no restart; sequence unchanged.
- Reset mid-search and restart:
  - Stimulus: reset asserted in DEC_WAIT with key=2.
  - Response: next cycle in IDLE, key=0, all start pulses and mem_wren low; a new start restarts cleanly from key 0.
  - Stimulus: start while in FOUND.
  - Response: new search from key 0, done drops 1 cycle later.
